// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard / stall / flush controller for a five-stage pipeline.
// FSM states INIT, RUN, MEMWAIT and HALT. Latch enables and flushes are
// combinational from state and inputs. halted, mem_timeout and the perf
// counters are registered.
// Optional feature: define PIPELINE_CTRL_PERF_EN to build the stall_cnt and
// flush_cnt performance counters. When it is undefined, both ports read 0.
//
// Latch handshake: a latch captures on the rising edge when its enable is 1.
// If its flush is also 1, it loads a bubble instead of its upstream value.
module pipeline_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        exmem_dreq,
    input  logic        idex_memread,
    input  logic [4:0]  idex_rd,
    input  logic [4:0]  ifid_rs,
    input  logic [4:0]  ifid_rt,
    input  logic        ex_redirect,
    input  logic        memwb_halt,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        halted,
    output logic        mem_timeout,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
    output logic [1:0]  state_dbg
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT_V = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_INIT    = 2'd0,
        S_RUN     = 2'd1,
        S_MEMWAIT = 2'd2,
        S_HALT    = 2'd3
    } state_t;

    state_t        state, next_state;
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] wait_nxt;
    logic          data_wait;
    logic          load_use;

    // In MEMWAIT the access is still outstanding, so only dhit ends the wait.
    assign data_wait = ~dhit & (exmem_dreq | (state == S_MEMWAIT));
    assign load_use  = idex_memread && (idex_rd != 5'd0) &&
                       ((idex_rd == ifid_rs) || (idex_rd == ifid_rt));
    assign wait_nxt  = (wait_cnt == TIMEOUT_V) ? wait_cnt : wait_cnt + CW'(1);
    assign state_dbg = state;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state <= S_INIT;
        else     state <= next_state;
    end

    // Next-state logic. A halt reaching MEM/WB overrides everything else.
    always_comb begin
        next_state = state;
        case (state)
            S_INIT:    next_state = S_RUN;
            S_RUN:     if (memwb_halt)     next_state = S_HALT;
                       else if (data_wait) next_state = S_MEMWAIT;
            S_MEMWAIT: if (memwb_halt)     next_state = S_HALT;
                       else if (dhit)      next_state = S_RUN;
            S_HALT:    next_state = S_HALT;
            default:   next_state = S_INIT;
        endcase
    end

    // Control outputs. RUN and a completing MEMWAIT share the same priority
    // chain: data wait > redirect > load-use > ihit miss > advance.
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (RST || state == S_INIT) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
            {ifid_flush, idex_flush, exmem_flush}         = 3'b111;
        end else if (state == S_RUN || state == S_MEMWAIT) begin
            if (data_wait) begin
                pc_en = 1'b0;
            end else if (ex_redirect) begin
                {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                {idex_en, exmem_en, memwb_en} = 3'b111;
                idex_flush = 1'b1;
            end else if (!ihit) begin
                {ifid_en, idex_en, exmem_en, memwb_en} = 4'b1111;
                ifid_flush = 1'b1;
            end else begin
                {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
            end
        end
    end

    // Memory wait counter, sticky timeout flag and sticky halted flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
            halted      <= 1'b0;
        end else begin
            if (state == S_RUN) begin
                wait_cnt <= '0;
            end else if (state == S_MEMWAIT && !dhit) begin
                wait_cnt <= wait_nxt;
                if (wait_nxt == TIMEOUT_V) mem_timeout <= 1'b1;
            end
            if (next_state == S_HALT) halted <= 1'b1;
        end
    end

`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] flush_q;

    // Performance counters. They wrap naturally at 2^32.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_en && state != S_HALT)
                stall_q <= stall_q + 32'd1;
            if ((ifid_flush || idex_flush || exmem_flush) && state != S_INIT)
                flush_q <= flush_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed bench for pipeline_ctrl, built with TIMEOUT=4.
// Control vector order: {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
//                        ifid_flush, idex_flush, exmem_flush}.
module tb_pipeline_ctrl;

    localparam logic [7:0] INIT_V  = 8'b11111_111;
    localparam logic [7:0] ADV_V   = 8'b11111_000;
    localparam logic [7:0] ZERO_V  = 8'b00000_000;
    localparam logic [7:0] REDIR_V = 8'b11111_110;
    localparam logic [7:0] LDUSE_V = 8'b00111_010;
    localparam logic [7:0] IMISS_V = 8'b01111_100;

    localparam logic [1:0] ST_INIT    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_MEMWAIT = 2'd2;
    localparam logic [1:0] ST_HALT    = 2'd3;

    logic        CLK, RST;
    logic        ihit, dhit, exmem_dreq, idex_memread;
    logic [4:0]  idex_rd, ifid_rs, ifid_rt;
    logic        ex_redirect, memwb_halt;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, exmem_flush;
    logic        halted, mem_timeout;
    logic [31:0] stall_cnt, flush_cnt;
    logic [1:0]  state_dbg;
    logic [7:0]  ctrl;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    pipeline_ctrl #(.TIMEOUT(4)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .exmem_dreq(exmem_dreq), .idex_memread(idex_memread),
        .idex_rd(idex_rd), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ex_redirect(ex_redirect), .memwb_halt(memwb_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .halted(halted),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt), .state_dbg(state_dbg)
    );

    assign ctrl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                   ifid_flush, idex_flush, exmem_flush};

    // Clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        ihit = 1'b1; dhit = 1'b0; exmem_dreq = 1'b0; idex_memread = 1'b0;
        idex_rd = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
        ex_redirect = 1'b0; memwb_halt = 1'b0;
    endtask

    // Check the control vector for the current cycle, account for it in the
    // counter model, then advance to 1 time unit after the next edge.
    task automatic tick(input string tag, input logic [7:0] exp,
                        input bit in_init, input bit in_halt);
        #2;
        check(tag, {24'd0, ctrl}, {24'd0, exp});
        if (!in_halt && !exp[7]) exp_stall++;
        if (!in_init && (exp[2:0] != 3'b000)) exp_flush++;
        @(posedge CLK);
        #1;
    endtask

    task automatic check_cnt(input string tag);
`ifdef PIPELINE_CTRL_PERF_EN
        check({tag, "_stall"}, stall_cnt, exp_stall);
        check({tag, "_flush"}, flush_cnt, exp_flush);
`else
        check({tag, "_stall"}, stall_cnt, 32'd0);
        check({tag, "_flush"}, flush_cnt, 32'd0);
`endif
    endtask

    task automatic do_reset(input string tag);
        RST = 1'b1;
        idle_inputs();
        #2;
        check({tag, "_ctrl_in_rst"}, {24'd0, ctrl}, {24'd0, INIT_V});
        @(posedge CLK);
        #1;
        RST = 1'b0;
        exp_stall = 0;
        exp_flush = 0;
        check({tag, "_state"}, {30'd0, state_dbg}, {30'd0, ST_INIT});
        check({tag, "_halted"}, {31'd0, halted}, 32'd0);
        check({tag, "_timeout"}, {31'd0, mem_timeout}, 32'd0);
        check_cnt(tag);
    endtask

    initial begin
        idle_inputs();
        do_reset("reset0");
        tick("init_flush", INIT_V, 1'b1, 1'b0);
        check("run_state", {30'd0, state_dbg}, {30'd0, ST_RUN});
        tick("run_adv", ADV_V, 1'b0, 1'b0);

        // Load-use hazards, and their non-hazard look-alikes.
        idex_memread = 1'b1; idex_rd = 5'd5; ifid_rs = 5'd3; ifid_rt = 5'd5;
        tick("lu_rt", LDUSE_V, 1'b0, 1'b0);
        idex_rd = 5'd7; ifid_rs = 5'd7; ifid_rt = 5'd1;
        tick("lu_rs", LDUSE_V, 1'b0, 1'b0);
        idex_rd = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
        tick("lu_rd0", ADV_V, 1'b0, 1'b0);
        idex_memread = 1'b0; idex_rd = 5'd9; ifid_rs = 5'd9;
        tick("lu_noread", ADV_V, 1'b0, 1'b0);
        idle_inputs();

        // Instruction miss.
        ihit = 1'b0;
        tick("imiss", IMISS_V, 1'b0, 1'b0);

        // Redirect beats load-use and an instruction miss.
        ex_redirect = 1'b1; idex_memread = 1'b1; idex_rd = 5'd5; ifid_rt = 5'd5;
        tick("redir_all", REDIR_V, 1'b0, 1'b0);
        check_cnt("after_redir");
        idle_inputs();

        // Three data-miss cycles, then dhit.
        exmem_dreq = 1'b1;
        tick("dwait0", ZERO_V, 1'b0, 1'b0);
        check("dwait_state", {30'd0, state_dbg}, {30'd0, ST_MEMWAIT});
        tick("dwait1", ZERO_V, 1'b0, 1'b0);
        tick("dwait2", ZERO_V, 1'b0, 1'b0);
        dhit = 1'b1;
        tick("dwait_done", ADV_V, 1'b0, 1'b0);
        check("dwait_back_run", {30'd0, state_dbg}, {30'd0, ST_RUN});
        check("dwait_no_timeout", {31'd0, mem_timeout}, 32'd0);
        check_cnt("after_dwait");

        // A completing MEMWAIT cycle goes through the normal priority chain.
        dhit = 1'b0;
        tick("dwait_b0", ZERO_V, 1'b0, 1'b0);
        dhit = 1'b1; ex_redirect = 1'b1; ihit = 1'b0;
        tick("dwait_b_redir", REDIR_V, 1'b0, 1'b0);
        idle_inputs();

        // Timeout after four MEMWAIT cycles with dhit held low.
        exmem_dreq = 1'b1;
        tick("to_entry", ZERO_V, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick("to_wait", ZERO_V, 1'b0, 1'b0);
        check("to_not_yet", {31'd0, mem_timeout}, 32'd0);
        tick("to_wait4", ZERO_V, 1'b0, 1'b0);
        check("to_set", {31'd0, mem_timeout}, 32'd1);
        tick("to_hold", ZERO_V, 1'b0, 1'b0);
        check("to_sticky", {31'd0, mem_timeout}, 32'd1);
        check("to_state", {30'd0, state_dbg}, {30'd0, ST_MEMWAIT});
        check_cnt("after_timeout");
        do_reset("reset_to");
        tick("init2", INIT_V, 1'b1, 1'b0);

        // Halt from RUN: the halting cycle itself still advances normally.
        memwb_halt = 1'b1;
        tick("halt_entry", ADV_V, 1'b0, 1'b0);
        check("halt_flag", {31'd0, halted}, 32'd1);
        check("halt_state", {30'd0, state_dbg}, {30'd0, ST_HALT});
        memwb_halt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ihit = 1'($urandom_range(0, 1));
            dhit = 1'($urandom_range(0, 1));
            exmem_dreq = 1'($urandom_range(0, 1));
            ex_redirect = 1'($urandom_range(0, 1));
            tick("halt_quiet", ZERO_V, 1'b0, 1'b1);
        end
        check("halt_still", {31'd0, halted}, 32'd1);
        check_cnt("after_halt");

        // Halt from MEMWAIT.
        do_reset("reset_halt");
        tick("init3", INIT_V, 1'b1, 1'b0);
        exmem_dreq = 1'b1;
        tick("mh_entry", ZERO_V, 1'b0, 1'b0);
        memwb_halt = 1'b1;
        tick("mh_wait", ZERO_V, 1'b0, 1'b0);
        check("mh_halted", {31'd0, halted}, 32'd1);
        check("mh_state", {30'd0, state_dbg}, {30'd0, ST_HALT});
        check_cnt("after_mh");
        do_reset("reset_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
